// File: rtl/l2_arb_pkg.sv
// ---------------------------------------------------------------------------
// l2_arb_pkg
// Shared types and constants for the L2 bank round-robin arbiter.
//   tcdm_req_t : one requester's payload {add, wen, wdata, be} at the default
//                bank geometry (15-bit word address, 32-bit data).
//   resp_tag_t : one response-pipeline stage {valid, idx}.
//   MAX_MEM_LATENCY : deepest supported SRAM read latency.
//   idx_width() : width of a requester index for a given requester count.
// ---------------------------------------------------------------------------
package l2_arb_pkg;

  localparam int MAX_MEM_LATENCY = 4;

  localparam int TCDM_ADDR_W = 15;
  localparam int TCDM_DATA_W = 32;
  localparam int TCDM_BE_W   = TCDM_DATA_W / 8;

  // Response tags carry a fixed-width index so the type does not depend on
  // the requester count; 8 bits covers any realistic crossbar.
  localparam int TAG_IDX_W = 8;

  typedef struct packed {
    logic [TCDM_ADDR_W-1:0] add;
    logic                   wen;
    logic [TCDM_DATA_W-1:0] wdata;
    logic [TCDM_BE_W-1:0]   be;
  } tcdm_req_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } resp_tag_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l2_bank_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// l2_bank_rr_arbiter_if
// Requester-side TCDM bundle of the L2 bank arbiter, all requesters flattened.
//   req_i/gnt_o       : per-requester request / grant
//   add_i/wen_i/wdata_i/be_i : per-requester payload (wen: 1 = read, 0 = write)
//   r_valid_o/r_rdata_o      : response valid (per requester) / broadcast data
// Modports: slave = arbiter side, master = requester side.
//
// Handshake: a requester raises req_i with a stable payload; the transfer
// happens in the cycle where req_i and gnt_o are both high. req_i may be
// dropped before a grant with no effect. Responses have no backpressure:
// r_valid_o pulses for exactly one cycle and must be accepted.
// ---------------------------------------------------------------------------
interface l2_bank_rr_arbiter_if #(
  parameter int N_REQ      = 6,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  logic [N_REQ-1:0]              req_i;
  logic [N_REQ-1:0]              gnt_o;
  logic [N_REQ*ADDR_WIDTH-1:0]   add_i;
  logic [N_REQ-1:0]              wen_i;
  logic [N_REQ*DATA_WIDTH-1:0]   wdata_i;
  logic [N_REQ*DATA_WIDTH/8-1:0] be_i;
  logic [N_REQ-1:0]              r_valid_o;
  logic [DATA_WIDTH-1:0]         r_rdata_o;

  modport slave (
    input  req_i, add_i, wen_i, wdata_i, be_i,
    output gnt_o, r_valid_o, r_rdata_o
  );

  modport master (
    output req_i, add_i, wen_i, wdata_i, be_i,
    input  gnt_o, r_valid_o, r_rdata_o
  );
endinterface

// File: rtl/rr_lzc_select.sv
// ---------------------------------------------------------------------------
// rr_lzc_select
// Rotating priority encoder: finds the first set request searching upward
// from ptr_i and wrapping modulo N_REQ.
//   req_i : request vector
//   ptr_i : highest-priority index this cycle (must be < N_REQ)
//   idx_o : winning index (0 when any_o is low)
//   any_o : at least one request is set
// ---------------------------------------------------------------------------
module rr_lzc_select #(
  parameter int N_REQ = 6,
  parameter int IDX_W = 3
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Walk the rotated order from lowest to highest priority so the last hit,
  // i.e. the one closest to ptr_i, is what remains in idx_o.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N_REQ]) begin
        idx_o = IDX_W'((int'(ptr_i) + k) % N_REQ);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_bank_rr_arbiter.sv
// ---------------------------------------------------------------------------
// l2_bank_rr_arbiter
// Shares one L2 SRAM bank between N_REQ TCDM requesters (AXI-bridge ports and
// uDMA channels). At most one access per cycle, round-robin priority, fixed
// latency responses tagged with the winner index.
//
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   tcdm           : requester bundle (slave modport)
//   mem_csn_o      : SRAM chip select, active-low
//   mem_wen_o      : SRAM write enable, active-low (same sense as wen_i)
//   mem_add_o, mem_wdata_o, mem_be_o : SRAM address / write data / byte enables
//   mem_rdata_i    : SRAM read data, valid MEM_LATENCY cycles after access
// Optional (macro L2_ARB_PERF_CNT_EN):
//   perf_cnt_o     : {conflict counter, grant counter N_REQ-1, ..., 0}, 32b each
//   perf_clr_i     : synchronous clear of all counters
// ---------------------------------------------------------------------------
module l2_bank_rr_arbiter
  import l2_arb_pkg::*;
#(
  parameter int N_REQ       = 6,
  parameter int ADDR_WIDTH  = 15,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  l2_bank_rr_arbiter_if.slave     tcdm,
  output logic                    mem_csn_o,
  output logic                    mem_wen_o,
  output logic [ADDR_WIDTH-1:0]   mem_add_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
`ifdef L2_ARB_PERF_CNT_EN
  ,
  output logic [(N_REQ+1)*32-1:0] perf_cnt_o,
  input  logic                    perf_clr_i
`endif
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int BE_W  = DATA_WIDTH / 8;
  // Out-of-range latencies are clamped to the supported 1..MAX_MEM_LATENCY.
  localparam int LAT   = (MEM_LATENCY < 1) ? 1 :
                         (MEM_LATENCY > MAX_MEM_LATENCY) ? MAX_MEM_LATENCY : MEM_LATENCY;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             grant_en;
  logic [N_REQ-1:0] gnt;
  resp_tag_t        pipe_q [LAT];

  rr_lzc_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_lzc_select (
    .req_i (tcdm.req_i),
    .ptr_i (rr_ptr_q),
    .idx_o (winner),
    .any_o (any_req)
  );

  // Grants are suppressed while reset is held so nothing reaches the SRAM.
  assign grant_en = any_req & ~rst_i;

  always_comb begin
    gnt = '0;
    if (grant_en) gnt[winner] = 1'b1;
  end
  assign tcdm.gnt_o = gnt;

  // Winner payload to the bank; idle cycles drive zeros with csn high.
  always_comb begin
    mem_csn_o   = 1'b1;
    mem_wen_o   = 1'b0;
    mem_add_o   = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (grant_en) begin
      mem_csn_o   = 1'b0;
      mem_wen_o   = tcdm.wen_i[winner];
      mem_add_o   = tcdm.add_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wdata_o = tcdm.wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
      mem_be_o    = tcdm.be_i[int'(winner)*BE_W +: BE_W];
    end
  end

  // Priority moves to the requester just after the one served.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_en) begin
      if (int'(winner) == N_REQ - 1) rr_ptr_d = '0;
      else                           rr_ptr_d = winner + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  // Response tag pipeline: every grant (read or write) produces one response
  // exactly LAT cycles later, lining up with mem_rdata_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0].valid <= grant_en;
      pipe_q[0].idx   <= grant_en ? TAG_IDX_W'(winner) : '0;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    tcdm.r_valid_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      tcdm.r_valid_o[i] = pipe_q[LAT-1].valid && (pipe_q[LAT-1].idx == TAG_IDX_W'(i));
    end
  end
  assign tcdm.r_rdata_o = mem_rdata_i;

`ifdef L2_ARB_PERF_CNT_EN
  // Words 0..N_REQ-1 count grants per requester; word N_REQ counts cycles
  // with more than one request pending. All saturate at all-ones.
  logic [31:0] cnt_q [N_REQ+1];
  logic        multi_req;

  assign multi_req = ($countones(tcdm.req_i) > 1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i <= N_REQ; i++) cnt_q[i] <= '0;
    end else if (perf_clr_i) begin
      for (int i = 0; i <= N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 32'd1;
      end
      if (multi_req && (cnt_q[N_REQ] != '1)) cnt_q[N_REQ] <= cnt_q[N_REQ] + 32'd1;
    end
  end

  always_comb begin
    perf_cnt_o = '0;
    for (int i = 0; i <= N_REQ; i++) perf_cnt_o[i*32 +: 32] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_bank_rr_arbiter
// Self-checking bench for l2_bank_rr_arbiter (N_REQ=6, MEM_LATENCY=2).
// A behavioural model keeps the "next priority" index, a word memory and a
// queue of expected responses stamped with their due cycle. A small SRAM
// model answers the DUT's mem_* port.
// ---------------------------------------------------------------------------
module tb_l2_bank_rr_arbiter;
  import l2_arb_pkg::*;

  localparam int N   = 6;
  localparam int AW  = 15;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_bank_rr_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic          mem_csn_o, mem_wen_o;
  logic [AW-1:0] mem_add_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic [BW-1:0] mem_be_o;
`ifdef L2_ARB_PERF_CNT_EN
  logic [(N+1)*32-1:0] perf_cnt_o;
  logic                perf_clr_i;
`endif

  l2_bank_rr_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tcdm        (bus),
    .mem_csn_o   (mem_csn_o),
    .mem_wen_o   (mem_wen_o),
    .mem_add_o   (mem_add_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_rdata_i (mem_rdata_i)
`ifdef L2_ARB_PERF_CNT_EN
    ,
    .perf_cnt_o  (perf_cnt_o),
    .perf_clr_i  (perf_clr_i)
`endif
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // ---------------- SRAM model ----------------
  logic [DW-1:0] sram    [32];
  logic [DW-1:0] rd_pipe [LAT];
  logic          sram_clear;

  always @(posedge clk) begin
    if (sram_clear) begin
      for (int i = 0; i < 32; i++) sram[i] <= '0;
    end else if (!mem_csn_o && !mem_wen_o) begin
      sram[mem_add_o[4:0]] <= merge(sram[mem_add_o[4:0]], mem_wdata_o, mem_be_o);
    end
    rd_pipe[0] <= (!mem_csn_o && mem_wen_o) ? sram[mem_add_o[4:0]] : '0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata_i = rd_pipe[LAT-1];

  // ---------------- stimulus state / driver ----------------
  logic [N-1:0] req;
  tcdm_req_t    pl [N];
  int           cyc;
  int           n_chk, n_fail;

  task automatic drive();
    bus.req_i = req;
    for (int i = 0; i < N; i++) begin
      bus.add_i[i*AW +: AW]   = pl[i].add;
      bus.wen_i[i]            = pl[i].wen;
      bus.wdata_i[i*DW +: DW] = pl[i].wdata;
      bus.be_i[i*BW +: BW]    = pl[i].be;
    end
  endtask

  task automatic set_pl(input int i, input logic [AW-1:0] a, input logic w,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
    pl[i].add = a; pl[i].wen = w; pl[i].wdata = d; pl[i].be = be;
  endtask

  task automatic rand_pl(input int i);
    set_pl(i, AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom(),
           BW'($urandom_range(0, 15)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [31:0]   due;
    logic [7:0]    idx;
    logic          rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            m_ptr;
  logic [DW-1:0] ref_mem [32];
  logic [N-1:0]  e_gnt, e_rv;
  int            e_win;
  logic          e_rd_chk;
  logic [DW-1:0] e_rdata;

  task automatic model_reset();
    m_ptr = 0;
    exp_q.delete();
  endtask

  // Evaluate one cycle for the current req/pl at cycle cyc.
  task automatic model_step();
    exp_t e;
    int   a;
    e_gnt = '0; e_rv = '0; e_rd_chk = 1'b0; e_rdata = '0; e_win = -1;
    for (int k = 0; k < N; k++) begin
      if (e_win < 0 && req[(m_ptr + k) % N]) e_win = (m_ptr + k) % N;
    end
    if (exp_q.size() > 0 && int'(exp_q[0].due) == cyc) begin
      e_rv[exp_q[0].idx] = 1'b1;
      e_rd_chk = exp_q[0].rd;
      e_rdata  = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    if (e_win >= 0) begin
      e_gnt[e_win] = 1'b1;
      a = int'(pl[e_win].add[4:0]);
      e.due = 32'(cyc + LAT);
      e.idx = 8'(e_win);
      e.rd  = pl[e_win].wen;
      e.data = ref_mem[a];
      if (!pl[e_win].wen) ref_mem[a] = merge(ref_mem[a], pl[e_win].wdata, pl[e_win].be);
      exp_q.push_back(e);
      m_ptr = (e_win + 1) % N;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req = '1;
    for (int i = 0; i < N; i++) set_pl(i, AW'(i + 1), 1'b0, 32'h1234_0000 + i, 4'hF);
    drive();
    #2;
    n_chk++; if (bus.gnt_o !== '0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0", bus.gnt_o); end
    n_chk++; if (mem_csn_o !== 1'b1) begin n_fail++; $display("FAIL reset_csn got=%b exp=1", mem_csn_o); end
    n_chk++; if (bus.r_valid_o !== '0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", bus.r_valid_o); end
    n_chk++; if (mem_add_o !== '0 || mem_wen_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem got add=%h wen=%b exp add=0 wen=0", mem_add_o, mem_wen_o);
    end
    tick();
    rst = 1'b0;
    req = '0;
    drive();
    model_reset();
  endtask

  task automatic test_idle();
    req = '0;
    for (int c = 0; c < 10; c++) begin
      drive();
      @(negedge clk);
      model_step();
      n_chk++; if (bus.gnt_o !== '0 || mem_csn_o !== 1'b1 || bus.r_valid_o !== '0) begin
        n_fail++; $display("FAIL idle cyc=%0d got gnt=%b csn=%b rv=%b exp 0/1/0", cyc, bus.gnt_o, mem_csn_o, bus.r_valid_o);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < N; i++) set_pl(i, AW'(i), 1'b1, '0, 4'hF);
    for (int c = 0; c < 2*N + LAT; c++) begin
      req = (c < 2*N) ? '1 : '0;
      drive();
      @(negedge clk);
      model_step();
      n_chk++; if (bus.gnt_o !== e_gnt) begin
        n_fail++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt_o, e_gnt);
      end
      if (c < 2*N) begin
        n_chk++; if (bus.gnt_o !== N'(1 << (c % N))) begin
          n_fail++; $display("FAIL rr_order step=%0d got=%b exp_idx=%0d", c, bus.gnt_o, c % N);
        end
      end
      n_chk++; if (bus.r_valid_o !== e_rv) begin
        n_fail++; $display("FAIL rr_rvalid cyc=%0d got=%b exp=%b", cyc, bus.r_valid_o, e_rv);
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    req = '0;
    set_pl(2, AW'(16), 1'b0, 32'hDEAD_BEEF, 4'hF);
    set_pl(5, AW'(16), 1'b1, 32'h0, 4'hF);
    for (int c = 0; c < 2 + LAT; c++) begin
      req = (c == 0) ? N'(1 << 2) : (c == 1) ? N'(1 << 5) : '0;
      drive();
      @(negedge clk);
      model_step();
      n_chk++; if (bus.gnt_o !== e_gnt || bus.r_valid_o !== e_rv) begin
        n_fail++; $display("FAIL wr_rd_hs cyc=%0d got gnt=%b rv=%b exp gnt=%b rv=%b", cyc, bus.gnt_o, bus.r_valid_o, e_gnt, e_rv);
      end
      if (c == 0) begin
        n_chk++; if (mem_csn_o !== 1'b0 || mem_wen_o !== 1'b0 || mem_add_o !== AW'(16) || mem_wdata_o !== 32'hDEAD_BEEF) begin
          n_fail++; $display("FAIL wr_mem got csn=%b wen=%b add=%h wd=%h exp 0/0/10/deadbeef", mem_csn_o, mem_wen_o, mem_add_o, mem_wdata_o);
        end
      end
      if (c == 1 + LAT) begin
        n_chk++; if (bus.r_valid_o !== N'(1 << 5) || bus.r_rdata_o !== 32'hDEAD_BEEF) begin
          n_fail++; $display("FAIL wr_rd_data got rv=%b rd=%h exp rv=100000 rd=deadbeef", bus.r_valid_o, bus.r_rdata_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_single_stream();
    set_pl(3, AW'(5), 1'b1, '0, 4'hF);
    for (int c = 0; c < 8 + LAT; c++) begin
      req = (c < 8) ? N'(1 << 3) : '0;
      drive();
      @(negedge clk);
      model_step();
      n_chk++; if (bus.gnt_o !== e_gnt) begin
        n_fail++; $display("FAIL stream_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt_o, e_gnt);
      end
      n_chk++; if (bus.r_valid_o !== ((c >= LAT) ? N'(1 << 3) : '0)) begin
        n_fail++; $display("FAIL stream_rvalid step=%0d got=%b exp_model=%b", c, bus.r_valid_o, e_rv);
      end
      tick();
    end
  endtask

  task automatic test_reset_inflight();
    set_pl(0, AW'(1), 1'b1, '0, 4'hF);
    set_pl(1, AW'(2), 1'b1, '0, 4'hF);
    set_pl(4, AW'(3), 1'b1, '0, 4'hF);
    req = N'(3);
    for (int c = 0; c < 2; c++) begin
      drive();
      @(negedge clk);
      model_step();
      n_chk++; if (bus.gnt_o !== e_gnt) begin
        n_fail++; $display("FAIL inflight_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt_o, e_gnt);
      end
      if (e_win >= 0) req[e_win] = 1'b0;
      tick();
    end
    rst = 1'b1;
    model_reset();
    req = N'(1 << 1) | N'(1 << 4);
    drive();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++; if (bus.r_valid_o !== '0 || bus.gnt_o !== '0) begin
        n_fail++; $display("FAIL inrst cyc=%0d got rv=%b gnt=%b exp 0/0", cyc, bus.r_valid_o, bus.gnt_o);
      end
      tick();
    end
    rst = 1'b0;
    for (int c = 0; c < 3 + LAT; c++) begin
      drive();
      @(negedge clk);
      model_step();
      if (c == 0) begin
        n_chk++; if (bus.gnt_o !== N'(1 << 1)) begin
          n_fail++; $display("FAIL post_rst_gnt got=%b exp=000010", bus.gnt_o);
        end
      end
      n_chk++; if (bus.gnt_o !== e_gnt || bus.r_valid_o !== e_rv) begin
        n_fail++; $display("FAIL post_rst cyc=%0d got gnt=%b rv=%b exp gnt=%b rv=%b", cyc, bus.gnt_o, bus.r_valid_o, e_gnt, e_rv);
      end
      if (e_win >= 0) req[e_win] = 1'b0;
      tick();
    end
  endtask

  task automatic test_random();
    req = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && c < 390 && $urandom_range(0, 99) < 40) begin
          req[i] = 1'b1;
          rand_pl(i);
        end else if (req[i] && $urandom_range(0, 99) < 3) begin
          req[i] = 1'b0;
        end
      end
      drive();
      @(negedge clk);
      model_step();
      n_chk++; if (bus.gnt_o !== e_gnt) begin
        n_fail++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt_o, e_gnt);
      end
      n_chk++; if (bus.r_valid_o !== e_rv) begin
        n_fail++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, bus.r_valid_o, e_rv);
      end
      if (e_rd_chk) begin
        n_chk++; if (bus.r_rdata_o !== e_rdata) begin
          n_fail++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, bus.r_rdata_o, e_rdata);
        end
      end
      if (e_win >= 0) begin
        n_chk++; if (mem_csn_o !== 1'b0 || mem_add_o !== pl[e_win].add || mem_wen_o !== pl[e_win].wen ||
                     (!pl[e_win].wen && (mem_wdata_o !== pl[e_win].wdata || mem_be_o !== pl[e_win].be))) begin
          n_fail++; $display("FAIL rnd_mem cyc=%0d got csn=%b add=%h wen=%b wd=%h be=%h exp add=%h wen=%b wd=%h be=%h",
                             cyc, mem_csn_o, mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o,
                             pl[e_win].add, pl[e_win].wen, pl[e_win].wdata, pl[e_win].be);
        end
        req[e_win] = 1'b0;
      end else begin
        n_chk++; if (mem_csn_o !== 1'b1) begin
          n_fail++; $display("FAIL rnd_csn cyc=%0d got=%b exp=1", cyc, mem_csn_o);
        end
      end
      tick();
    end
  endtask

`ifdef L2_ARB_PERF_CNT_EN
  task automatic test_perf();
    req = '0; drive();
    perf_clr_i = 1'b1;
    tick();
    perf_clr_i = 1'b0;
    set_pl(0, AW'(1), 1'b1, '0, 4'hF);
    set_pl(1, AW'(2), 1'b1, '0, 4'hF);
    req = N'(3); drive();
    repeat (10) tick();
    req = '0; drive();
    @(negedge clk);
    n_chk++; if (perf_cnt_o[0 +: 32] !== 32'd5 || perf_cnt_o[32 +: 32] !== 32'd5) begin
      n_fail++; $display("FAIL perf_gnt got c0=%0d c1=%0d exp 5/5", perf_cnt_o[0 +: 32], perf_cnt_o[32 +: 32]);
    end
    n_chk++; if (perf_cnt_o[N*32 +: 32] !== 32'd10) begin
      n_fail++; $display("FAIL perf_conflict got=%0d exp=10", perf_cnt_o[N*32 +: 32]);
    end
    tick();
    perf_clr_i = 1'b1;
    tick();
    perf_clr_i = 1'b0;
    @(negedge clk);
    n_chk++; if (perf_cnt_o !== '0) begin
      n_fail++; $display("FAIL perf_clear got=%h exp=0", perf_cnt_o);
    end
    tick();
  endtask
`endif

  // ---------------- main sequence / report ----------------
  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) set_pl(i, '0, 1'b1, '0, '0);
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    drive();
    sram_clear = 1'b1;
`ifdef L2_ARB_PERF_CNT_EN
    perf_clr_i = 1'b0;
`endif
    model_reset();
    repeat (2) tick();
    sram_clear = 1'b0;

    test_reset();
    test_idle();
    test_round_robin();
    test_write_read();
    test_single_stream();
    test_reset_inflight();
    test_random();
`ifdef L2_ARB_PERF_CNT_EN
    test_perf();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
